// File: rtl/paralelo_serial_tx_pkg.sv
// paralelo_serial_tx_pkg: shared constants for the parallel-to-serial transmitter.
package paralelo_serial_tx_pkg;
   localparam logic [7:0] COM_DEF   = 8'hBC;
   localparam logic [7:0] IDLE_DEF  = 8'h7C;
   localparam int         CNT_W     = 3;
   localparam logic [0:0] ST_SYNC   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;
endpackage

// File: rtl/paralelo_serial_tx_piso_shift8.sv
// piso_shift8: 8-bit load/shift register with a registered MSB output.
module piso_shift8 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [7:0] din_i,
   output logic       msb_o
);
   logic [7:0] shift_q;
   logic       msb_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q <= '0;
         msb_q   <= 1'b0;
      end else if (load_i) begin
         msb_q   <= din_i[7];
         shift_q <= {din_i[6:0], 1'b0};
      end else begin
         msb_q   <= shift_q[7];
         shift_q <= {shift_q[6:0], 1'b0};
      end
   end
   assign msb_o = msb_q;
endmodule

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: byte-to-serial transmitter with comma sync, then data/idle fill.
// Define PARALELO_SERIAL_IDLE_COUNT_EN to add the saturating idle_count output.
module paralelo_serial_tx
   import paralelo_serial_tx_pkg::*;
#(
   parameter logic [7:0] COM         = COM_DEF,
   parameter logic [7:0] IDLE        = IDLE_DEF,
   parameter int         SYNC_COMMAS = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       data_out,
   output logic       active,
   output logic       byte_strobe
`ifdef PARALELO_SERIAL_IDLE_COUNT_EN
   ,output logic [15:0] idle_count
`endif
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [0:0]       state_q, state_d;
   logic [3:0]       comma_q, comma_d;
   logic             strobe_q;
   logic             load;
   logic [7:0]       next_byte;
   always_comb begin
      load      = cnt_q == '0;
      next_byte = (state_q == ST_ACTIVE) ? (valid_in ? data_in : IDLE) : COM;
      cnt_d     = cnt_q + 3'd1;
      comma_d   = (load && state_q == ST_SYNC) ? comma_q + 4'd1 : comma_q;
      state_d   = (load && state_q == ST_SYNC && comma_q == 4'(SYNC_COMMAS - 1)) ? ST_ACTIVE : state_q;
   end
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         cnt_q    <= '0;
         state_q  <= ST_SYNC;
         comma_q  <= '0;
         strobe_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         comma_q  <= comma_d;
         strobe_q <= load;
      end
   end
   piso_shift8 u_piso (
      .clk_i  (clk_32f),
      .rst_i  (reset),
      .load_i (load),
      .din_i  (next_byte),
      .msb_o  (data_out)
   );
   assign active      = state_q == ST_ACTIVE;
   assign byte_strobe = strobe_q;
`ifdef PARALELO_SERIAL_IDLE_COUNT_EN
   logic [15:0] idle_q;
   always_ff @(posedge clk_32f) begin
      if (reset)
         idle_q <= '0;
      else if (load && state_q == ST_ACTIVE && !valid_in && idle_q != 16'hFFFF)
         idle_q <= idle_q + 16'd1;
   end
   assign idle_count = idle_q;
`endif
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: directed self-checking bench for paralelo_serial_tx.
module tb_paralelo_serial_tx;
   logic       clk_32f = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       data_out;
   logic       active;
   logic       byte_strobe;
`ifdef PARALELO_SERIAL_IDLE_COUNT_EN
   logic [15:0] idle_count;
`endif
   int checks = 0;
   int errors = 0;

   paralelo_serial_tx dut (
      .clk_32f     (clk_32f),
      .reset       (reset),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .data_out    (data_out),
      .active      (active),
      .byte_strobe (byte_strobe)
`ifdef PARALELO_SERIAL_IDLE_COUNT_EN
      ,.idle_count (idle_count)
`endif
   );

   always #5 clk_32f = ~clk_32f;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_32f);
      #1;
   endtask

   // One byte period starting at a load edge; inputs are scrambled after the load
   // edge so any sampling outside it shows up in the stream.
   task automatic send_byte(input logic v, input logic [7:0] d, output logic [7:0] got,
                            output logic stb1, output logic stb2, output logic act1);
      valid_in = v;
      data_in  = d;
      got      = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 0) begin
            stb1     = byte_strobe;
            act1     = active;
            valid_in = ~v;
            data_in  = ~d;
         end
         if (i == 1) stb2 = byte_strobe;
         got = {got[6:0], data_out};
      end
   endtask

   logic [7:0] b;
   logic       s1, s2, a1;

   initial begin
      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 8'h00;
      for (int i = 0; i < 3; i++) step();
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_strobe", 32'(byte_strobe), 32'd0);
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         send_byte(1'b1, 8'h3C, b, s1, s2, a1);
         chk("sync_com", 32'(b), 32'hBC);
         chk("sync_strobe_load", 32'(s1), 32'd1);
         chk("sync_strobe_next", 32'(s2), 32'd0);
         chk("sync_active", 32'(a1), (n == 3) ? 32'd1 : 32'd0);
      end
      send_byte(1'b0, 8'h00, b, s1, s2, a1);
      chk("first_idle", 32'(b), 32'h7C);
      chk("active_hold", 32'(active), 32'd1);
      send_byte(1'b1, 8'hA5, b, s1, s2, a1);
      chk("data_a5", 32'(b), 32'hA5);
      chk("a5_strobe", 32'(s1), 32'd1);
      send_byte(1'b1, 8'h01, b, s1, s2, a1);
      chk("data_01", 32'(b), 32'h01);
      send_byte(1'b0, 8'hFF, b, s1, s2, a1);
      chk("idle_fill", 32'(b), 32'h7C);
      send_byte(1'b1, 8'hFF, b, s1, s2, a1);
      chk("data_ff", 32'(b), 32'hFF);
      send_byte(1'b1, 8'hBC, b, s1, s2, a1);
      chk("data_com_raw", 32'(b), 32'hBC);
      send_byte(1'b1, 8'h7C, b, s1, s2, a1);
      chk("data_idle_raw", 32'(b), 32'h7C);
      valid_in = 1'b1;
      data_in  = 8'hA5;
      for (int i = 0; i < 4; i++) step();
      reset = 1'b1;
      step();
      chk("midrst_data_out", 32'(data_out), 32'd0);
      chk("midrst_active", 32'(active), 32'd0);
      chk("midrst_strobe", 32'(byte_strobe), 32'd0);
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         send_byte(1'b1, 8'hA5, b, s1, s2, a1);
         chk("resync_com", 32'(b), 32'hBC);
         chk("resync_active", 32'(a1), (n == 3) ? 32'd1 : 32'd0);
      end
      for (int n = 0; n < 10; n++) begin
         send_byte(1'b0, 8'h55, b, s1, s2, a1);
         chk("idle_run", 32'(b), 32'h7C);
      end
`ifdef PARALELO_SERIAL_IDLE_COUNT_EN
      chk("idle_count", 32'(idle_count), 32'd10);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
